// File: rtl/mesi_isc_tb_mem_responder.sv
// mesi_isc_tb_mem_responder: round-robin mbus memory responder with programmable ack latency
module mesi_isc_tb_mem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 4,
  parameter int LATENCY        = 2,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               mbus_cmd_array     [3:0],
  input  logic [ADDR_WIDTH-1:0]    mbus_addr_array    [3:0],
  input  logic [DATA_WIDTH-1:0]    mbus_data_wr_array [3:0],
  output logic [DATA_WIDTH-1:0]    mbus_data_rd,
  output logic [3:0]               mbus_ack,
  output logic                     busy,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);
  typedef enum logic [2:0] {IDLE, GRANT, WAIT, ACK, HOLD} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];
  logic [1:0] rr, gid, pick;
  logic found, go_ack, is_rd, is_wr;
  logic [2:0] cmd_q;
  logic [MEM_DEPTH_LOG2-1:0] idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0] cnt;
  logic unused_addr;
  assign unused_addr = ^{mbus_addr_array[0], mbus_addr_array[1], mbus_addr_array[2], mbus_addr_array[3]};
  // Scan downward so the requester closest to the rr pointer wins.
  always_comb begin
    pick = rr;
    found = 1'b0;
    for (int i = 3; i >= 0; i--)
      if (mbus_cmd_array[rr + 2'(i)] != 3'd0) begin
        pick = rr + 2'(i);
        found = 1'b1;
      end
  end
  assign is_wr = cmd_q == 3'd1 || cmd_q == 3'd3;
  assign is_rd = cmd_q == 3'd2 || cmd_q == 3'd4;
  assign go_ack = (state == GRANT && LATENCY == 0) || (state == WAIT && cnt == 4'd1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rr <= '0;
      gid <= '0;
      cmd_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      mbus_ack <= '0;
      mbus_data_rd <= '0;
      busy <= 1'b0;
      err_cnt <= '0;
      for (int i = 0; i < 2**MEM_DEPTH_LOG2; i++) mem[i] <= '0;
    end else begin
      mbus_ack <= go_ack ? 4'b0001 << gid : 4'd0;
      if (go_ack && is_rd) mbus_data_rd <= mem[idx_q];
      case (state)
        IDLE: if (found) begin
          gid <= pick;
          cmd_q <= mbus_cmd_array[pick];
          idx_q <= mbus_addr_array[pick][MEM_DEPTH_LOG2+1:2];
          wdata_q <= mbus_data_wr_array[pick];
          busy <= 1'b1;
          state <= GRANT;
        end
        GRANT: begin
          cnt <= 4'(LATENCY);
          state <= LATENCY == 0 ? ACK : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          state <= cnt == 4'd1 ? ACK : WAIT;
        end
        ACK: begin
          if (is_wr) mem[idx_q] <= wdata_q;
          if (!is_wr && !is_rd && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          rr <= gid + 2'd1;
          state <= HOLD;
        end
        HOLD: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mesi_isc_tb_mem_responder.sv
// tb_mesi_isc_tb_mem_responder: table, directed and random checks against a transaction-level model
module tb_mesi_isc_tb_mem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0]  cmd [3:0], cmd0 [3:0];
  logic [31:0] addr [3:0], addr0 [3:0], wdata [3:0], wdata0 [3:0];
  logic [31:0] data_rd, data_rd0;
  logic [3:0]  ack, ack0;
  logic        busy, busy0;
  logic [7:0]  err_cnt, err_cnt0;
  always #5 clk = ~clk;

  mesi_isc_tb_mem_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mbus_cmd_array(cmd), .mbus_addr_array(addr),
    .mbus_data_wr_array(wdata), .mbus_data_rd(data_rd), .mbus_ack(ack),
    .busy(busy), .err_cnt(err_cnt));

  mesi_isc_tb_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .mbus_cmd_array(cmd0), .mbus_addr_array(addr0),
    .mbus_data_wr_array(wdata0), .mbus_data_rd(data_rd0), .mbus_ack(ack0),
    .busy(busy0), .err_cnt(err_cnt0));

  int checks = 0, failures = 0;
  logic [31:0] mem_m [16];
  logic [31:0] rd_m;
  int rr_m, err_m;
  logic [3:0] got_ack;
  logic [31:0] got_rd;

  typedef struct {
    int          port;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_req();
    for (int i = 0; i < 4; i++) if (cmd[i] != 3'd0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_cmds();
    for (int i = 0; i < 4; i++) begin
      cmd[i] = '0; addr[i] = '0; wdata[i] = '0;
      cmd0[i] = '0; addr0[i] = '0; wdata0[i] = '0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    rd_m = '0; rr_m = 0; err_m = 0;
  endtask

  // Serve one request on the LATENCY=2 instance; DUT must be idle with cmds applied.
  task automatic serve();
    int w, n;
    logic [2:0] c;
    logic [3:0] idx;
    logic [31:0] exp_rd;
    w = -1;
    for (int i = 0; i < 4; i++) if (w < 0 && cmd[(rr_m + i) % 4] != 3'd0) w = (rr_m + i) % 4;
    c = cmd[w];
    idx = addr[w][5:2];
    exp_rd = (c == 3'd2 || c == 3'd4) ? mem_m[idx] : rd_m;
    n = 0;
    do begin step(); n++; end while (ack == 4'd0 && n < 12);
    chk("latency", n, LAT + 2);
    chk("ack", {28'd0, ack}, 32'd1 << w);
    chk("data_rd", data_rd, exp_rd);
    chk("busy_ack", {31'd0, busy}, 32'd1);
    got_ack = ack;
    got_rd = data_rd;
    cmd[w] = 3'd0;
    if (c == 3'd1 || c == 3'd3) mem_m[idx] = wdata[w];
    else if (c >= 3'd5) err_m = err_m == 255 ? 255 : err_m + 1;
    rd_m = exp_rd;
    rr_m = (w + 1) % 4;
    step();
    chk("ack_hold", {28'd0, ack}, 32'd0);
    chk("err_cnt", {24'd0, err_cnt}, err_m);
    step();
  endtask

  initial begin
    clear_cmds();
    model_reset();
    tbl[0] = '{0, 3'd2, 32'h0000_0010, 32'h0,         4'b0001, 32'h0};
    tbl[1] = '{1, 3'd1, 32'h0000_0008, 32'hDEADBEEF,  4'b0010, 32'h0};
    tbl[2] = '{2, 3'd2, 32'h0000_0048, 32'h0,         4'b0100, 32'hDEADBEEF};
    tbl[3] = '{0, 3'd6, 32'h0000_0008, 32'h5555_5555, 4'b0001, 32'hDEADBEEF};
    tbl[4] = '{3, 3'd3, 32'h0000_0014, 32'h0000_1234, 4'b1000, 32'hDEADBEEF};
    tbl[5] = '{0, 3'd4, 32'hFF00_0054, 32'h0,         4'b0001, 32'h0000_1234};
    tbl[6] = '{1, 3'd2, 32'h0000_0088, 32'h0,         4'b0010, 32'hDEADBEEF};

    repeat (2) step();
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    chk("rst_rd", data_rd, 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_ack", {28'd0, ack}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 4; i++) begin cmd[i] = 3'd2; addr[i] = 32'h40 * i + 32'h4 * i; end
    for (int i = 0; i < 4; i++) begin
      serve();
      chk("rr_order", {28'd0, got_ack}, 32'd1 << i);
      chk("rr_rd_zero", got_rd, 32'd0);
    end
    cmd[3] = 3'd2; cmd[0] = 3'd2;
    serve();
    chk("wrap_first", {28'd0, got_ack}, 32'b0001);
    serve();
    chk("wrap_second", {28'd0, got_ack}, 32'b1000);

    for (int v = 0; v < 7; v++) begin
      cmd[tbl[v].port] = tbl[v].cmd;
      addr[tbl[v].port] = tbl[v].addr;
      wdata[tbl[v].port] = tbl[v].wdata;
      serve();
      chk($sformatf("tbl%0d_ack", v), {28'd0, got_ack}, {28'd0, tbl[v].ack});
      chk($sformatf("tbl%0d_rd", v), got_rd, tbl[v].rd);
    end
    chk("tbl_err", {24'd0, err_cnt}, 32'd1);

    cmd[0] = 3'd1; addr[0] = 32'h14; wdata[0] = 32'hAAAA_AAAA;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("abort_ack", {28'd0, ack}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    cmd[0] = 3'd0;
    repeat (3) begin
      step();
      chk("abort_no_ack", {28'd0, ack}, 32'd0);
    end
    rst = 1'b1;
    model_reset();
    step();
    cmd[0] = 3'd2; addr[0] = 32'h14;
    serve();
    chk("abort_rd", got_rd, 32'd0);
    cmd[0] = 3'd1; addr[0] = 32'h14; wdata[0] = 32'h1234;
    serve();
    cmd[0] = 3'd4; addr[0] = 32'h0000_0114;
    serve();
    chk("rdb_rd", got_rd, 32'h1234);

    cmd0[2] = 3'd2; addr0[2] = 32'h20;
    step();
    chk("l0_busy_t1", {31'd0, busy0}, 32'd1);
    chk("l0_ack_t1", {28'd0, ack0}, 32'd0);
    step();
    chk("l0_ack_t2", {28'd0, ack0}, 32'b0100);
    chk("l0_busy_t2", {31'd0, busy0}, 32'd1);
    chk("l0_rd", data_rd0, 32'd0);
    cmd0[2] = 3'd0;
    step();
    chk("l0_busy_t3", {31'd0, busy0}, 32'd1);
    chk("l0_ack_t3", {28'd0, ack0}, 32'd0);
    step();
    chk("l0_busy_t4", {31'd0, busy0}, 32'd0);

    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = $urandom_range(0, 9);
        cmd[i] = k < 3 ? 3'd0 : 3'(k - 2);
        addr[i] = $urandom;
        wdata[i] = $urandom;
      end
      if (!any_req()) cmd[$urandom_range(0, 3)] = 3'd2;
      for (int g = 0; g < 4 && any_req(); g++) serve();
    end

    for (int i = 0; i < 300; i++) begin
      cmd[0] = 3'(5 + $urandom_range(0, 2));
      addr[0] = $urandom;
      serve();
    end
    chk("err_sat", {24'd0, err_cnt}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
